// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 key schedule, one round key per request
//
// Ports:
//   clk      in   1    rising-edge clock
//   rst      in   1    asynchronous active-low reset
//   key_in   in   128  cipher key, byte k0 at [127:120] .. k15 at [7:0]
//   key_load in   1    pulse: capture key_in as round-0 key (wins over next_req)
//   next_req in   1    pulse: compute the next round key (ignored unless HOLD, rnd<10)
//   rk       out  128  current round key, same byte order as key_in
//   rk_valid out  1    rk is stable and corresponds to rnd
//   rnd      out  4    round index of rk, 0..10
//   busy     out  1    round-key computation in progress
//   done     out  1    rk holds the round-10 key and is valid
module key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         next_req,
  output logic [127:0] rk,
  output logic         rk_valid,
  output logic [3:0]   rnd,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, HOLD, SUB, XOR} state_t;

  state_t state, state_nxt;

  logic [1:0]  cnt;
  logic [31:0] temp;
  logic [7:0]  sub_in;
  logic [7:0]  sub_out;
  logic [7:0]  rcon;
  logic        start;
  logic [31:0] t_rc, w0n, w1n, w2n, w3n;

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte selected for this cycle's lookup: walks RotWord(w3) = w3 bytes 1,2,3,0.
  always_comb begin
    sub_in = rk[23:16];
    case (cnt)
      2'd0: sub_in = rk[23:16];
      2'd1: sub_in = rk[15:8];
      2'd2: sub_in = rk[7:0];
      2'd3: sub_in = rk[31:24];
      default: sub_in = rk[23:16];
    endcase
  end

  assign sub_out = SBOX[11'd2047 - {sub_in, 3'b000} -: 8];

  // rcon for the round being produced (rnd+1); rnd is 0..9 whenever XOR runs.
  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_rc = temp ^ {rcon, 24'h000000};
  assign w0n  = rk[127:96] ^ t_rc;
  assign w1n  = rk[95:64]  ^ w0n;
  assign w2n  = rk[63:32]  ^ w1n;
  assign w3n  = rk[31:0]   ^ w2n;

  assign start = (state == HOLD) && next_req && (rnd < 4'd10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        HOLD: if (start) state_nxt = SUB;
        SUB:  if (cnt == 2'd3) state_nxt = XOR;
        XOR:  state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk       <= '0;
      rnd      <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      temp     <= '0;
    end else if (key_load) begin
      rk       <= key_in;
      rnd      <= '0;
      rk_valid <= 1'b1;
      busy     <= 1'b0;
      cnt      <= '0;
      temp     <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (start) begin
            rk_valid <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        SUB: begin
          case (cnt)
            2'd0: temp[31:24] <= sub_out;
            2'd1: temp[23:16] <= sub_out;
            2'd2: temp[15:8]  <= sub_out;
            2'd3: temp[7:0]   <= sub_out;
            default: temp[31:24] <= sub_out;
          endcase
          cnt <= cnt + 2'd1;
        end
        XOR: begin
          rk       <= {w0n, w1n, w2n, w3n};
          rnd      <= rnd + 4'd1;
          rk_valid <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign done = rk_valid & (rnd == 4'd10);

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - self-checking bench for key_expand against a FIPS-197 style model
module tb_key_expand;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         next_req;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rnd;
  logic         busy;
  logic         done;

  int checks;
  int failures;
  logic [7:0] sb [256];

  key_expand dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .next_req(next_req), .rk(rk), .rk_valid(rk_valid), .rnd(rnd),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_model(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h1b) : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] rot, t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rot = {w[3][23:0], w[3][31:24]};
    t = {sb[rot[31:24]], sb[rot[23:16]], sb[rot[15:8]], sb[rot[7:0]]};
    t[31:24] = t[31:24] ^ rcon_model(r);
    w[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  task automatic request(output int lat);
    next_req = 1'b1;
    step();
    next_req = 1'b0;
    lat = 1;
    while (!rk_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; key_in = '0; key_load = 1'b0; next_req = 1'b0;
    step(); step();
    checks++;
    if ({rk, rnd, rk_valid, busy, done} !== {128'h0, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: got rk=%h rnd=%0d v=%b b=%b d=%b expected all zero", rk, rnd, rk_valid, busy, done);
    end
    rst = 1'b1;
    next_req = 1'b1; step(); next_req = 1'b0;
    repeat (7) step();
    checks++;
    if ({rk_valid, busy, rnd} !== {2'b00, 4'd0}) begin
      failures++;
      $display("FAIL idle_next_req: got v=%b b=%b rnd=%0d expected v=0 b=0 rnd=0", rk_valid, busy, rnd);
    end
  endtask

  task automatic test_round1();
    int lat;
    load(128'h000102030405060708090a0b0c0d0e0f);
    checks++;
    if ({rk, rnd, rk_valid, busy} !== {128'h000102030405060708090a0b0c0d0e0f, 4'd0, 2'b10}) begin
      failures++;
      $display("FAIL load_key: got rk=%h rnd=%0d v=%b b=%b expected key rnd=0 v=1 b=0", rk, rnd, rk_valid, busy);
    end
    next_req = 1'b1; step(); next_req = 1'b0;
    checks++;
    if ({rk_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL busy_flags: got v=%b b=%b expected v=0 b=1", rk_valid, busy);
    end
    lat = 1;
    while (!rk_valid && lat < 20) begin step(); lat++; end
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL latency: got %0d expected 6", lat);
    end
    checks++;
    if ({rk, rnd, busy} !== {128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL round1_0f: got rk=%h rnd=%0d expected d6aa74fdd2af72fadaa678f1d6ab76fe rnd=1", rk, rnd);
    end
  endtask

  task automatic test_full_schedule(input logic [127:0] k, input logic [127:0] r10_known);
    int lat;
    logic [127:0] exp;
    load(k);
    exp = k;
    for (int r = 1; r <= 10; r++) begin
      exp = next_rk(exp, r);
      request(lat);
      checks++;
      if ({rk, rnd, lat} !== {exp, r[3:0], 32'd6}) begin
        failures++;
        $display("FAIL schedule_r%0d: got rk=%h rnd=%0d lat=%0d expected rk=%h rnd=%0d lat=6", r, rk, rnd, lat, exp, r);
      end
      checks++;
      if (done !== (r == 10)) begin
        failures++;
        $display("FAIL done_r%0d: got %b expected %b", r, done, (r == 10));
      end
    end
    checks++;
    if (rk !== r10_known) begin
      failures++;
      $display("FAIL round10_known: got %h expected %h", rk, r10_known);
    end
    next_req = 1'b1; step(); next_req = 1'b0;
    repeat (7) step();
    checks++;
    if ({rk, rnd, rk_valid, busy, done} !== {r10_known, 4'd10, 3'b101}) begin
      failures++;
      $display("FAIL eleventh_req: got rk=%h rnd=%0d v=%b b=%b d=%b expected unchanged rnd=10 v=1 b=0 d=1", rk, rnd, rk_valid, busy, done);
    end
  endtask

  task automatic test_round1_2b7e();
    int lat;
    load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    request(lat);
    checks++;
    if (rk !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      failures++;
      $display("FAIL round1_2b7e: got %h expected a0fafe1788542cb123a339392a6c7605", rk);
    end
  endtask

  task automatic test_random_keys();
    int lat;
    logic [127:0] k, exp;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load(k);
      exp = k;
      for (int r = 1; r <= 10; r++) begin
        exp = next_rk(exp, r);
        request(lat);
        checks++;
        if ({rk, rnd} !== {exp, r[3:0]}) begin
          failures++;
          $display("FAIL random_key%0d_r%0d: got rk=%h rnd=%0d expected rk=%h rnd=%0d", n, r, rk, rnd, exp, r);
        end
      end
    end
  endtask

  task automatic test_request_during();
    int lat;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    load(k);
    next_req = 1'b1; step(); next_req = 1'b0;
    step();
    next_req = 1'b1; step(); next_req = 1'b0;
    lat = 3;
    while (!rk_valid && lat < 20) begin step(); lat++; end
    checks++;
    if ({lat, rnd, rk} !== {32'd6, 4'd1, next_rk(k, 1)}) begin
      failures++;
      $display("FAIL req_during_busy: got lat=%0d rnd=%0d rk=%h expected lat=6 rnd=1 rk=%h", lat, rnd, rk, next_rk(k, 1));
    end
    repeat (8) step();
    checks++;
    if ({rnd, rk_valid, busy} !== {4'd1, 2'b10}) begin
      failures++;
      $display("FAIL req_not_queued: got rnd=%0d v=%b b=%b expected rnd=1 v=1 b=0", rnd, rk_valid, busy);
    end
  endtask

  task automatic test_abort_load();
    int lat;
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    load(k1);
    next_req = 1'b1; step(); next_req = 1'b0;
    step();
    load(k2);
    checks++;
    if ({rk, rnd, rk_valid, busy} !== {k2, 4'd0, 2'b10}) begin
      failures++;
      $display("FAIL abort_load: got rk=%h rnd=%0d v=%b b=%b expected rk=%h rnd=0 v=1 b=0", rk, rnd, rk_valid, busy, k2);
    end
    request(lat);
    checks++;
    if ({rk, rnd} !== {next_rk(k2, 1), 4'd1}) begin
      failures++;
      $display("FAIL after_abort_r1: got rk=%h rnd=%0d expected rk=%h rnd=1", rk, rnd, next_rk(k2, 1));
    end
  endtask

  task automatic test_reset_mid();
    load({$urandom, $urandom, $urandom, $urandom});
    next_req = 1'b1; step(); next_req = 1'b0;
    repeat (4) step();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({rk, rnd, rk_valid, busy, done} !== {128'h0, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL async_reset: got rk=%h rnd=%0d v=%b b=%b d=%b expected all zero", rk, rnd, rk_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    next_req = 1'b1; step(); next_req = 1'b0;
    repeat (7) step();
    checks++;
    if ({rk, rnd, rk_valid, busy} !== {128'h0, 4'd0, 2'b00}) begin
      failures++;
      $display("FAIL post_reset_req: got rk=%h rnd=%0d v=%b b=%b expected zero/idle", rk, rnd, rk_valid, busy);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    load(k1);
    repeat (3) request(lat);
    checks++;
    if (rnd !== 4'd3) begin
      failures++;
      $display("FAIL pre_simul_rnd: got %0d expected 3", rnd);
    end
    key_in = k2; key_load = 1'b1; next_req = 1'b1;
    step();
    key_load = 1'b0; next_req = 1'b0;
    checks++;
    if ({rk, rnd, rk_valid, busy} !== {k2, 4'd0, 2'b10}) begin
      failures++;
      $display("FAIL simul_load_req: got rk=%h rnd=%0d v=%b b=%b expected rk=%h rnd=0 v=1 b=0", rk, rnd, rk_valid, busy, k2);
    end
    repeat (7) step();
    checks++;
    if ({rk, rnd, rk_valid} !== {k2, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL simul_stable: got rk=%h rnd=%0d v=%b expected rk=%h rnd=0 v=1", rk, rnd, rk_valid, k2);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_model(i[7:0]);
    rst = 1'b0; key_in = '0; key_load = 1'b0; next_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_round1();
    test_round1_2b7e();
    test_full_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_full_schedule(128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    test_random_keys();
    test_request_during();
    test_abort_load();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
